// File: rtl/blink_counter_if.sv
// Command port of the blink_counter timebase: a valid/ready transfer of opcode plus load data.
interface blink_counter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/blink_counter.sv
// Prescaled 16-bit timebase with START/STOP/LOAD/CLEAR command port and tick/wrap pulses.
// Optional down counting is enabled by defining BLINK_COUNTER_DIR_EN.
module blink_counter #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  blink_counter_if.slave        cmd,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef BLINK_COUNTER_DIR_EN
  input  logic                  dir_down,
`endif
  output logic [15:0]           current_count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  running
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             count;
  logic [15:0]             count_nxt;
  logic [PRESCALE_W-1:0]   pre_cnt;
  logic [PRESCALE_W-1:0]   pre_nxt;
  logic [PRESCALE_W-1:0]   pre_max;
  logic [PRESCALE_W-1:0]   max_nxt;
  logic [15:0]             pend;
  logic [15:0]             pend_nxt;
  logic                    accept;
  logic                    down;
  logic [15:0]             step_val;
  logic                    wrap_hit;

`ifdef BLINK_COUNTER_DIR_EN
  assign down = dir_down;
`else
  assign down = 1'b0;
`endif

  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign step_val      = down ? (count - 16'd1) : (count + 16'd1);
  assign wrap_hit      = down ? (count == 16'h0000) : (count == 16'hFFFF);
  assign current_count = count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: an accepted command overrides the pending-load completion
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (cmd.cmd_op)
        OP_START: state_nxt = RUN;
        OP_STOP:  state_nxt = IDLE;
        OP_LOAD:  state_nxt = (state == IDLE) ? IDLE : LOAD_WAIT;
        OP_CLEAR: state_nxt = state;
        default:  state_nxt = state;
      endcase
    end else if (tick && (state == LOAD_WAIT)) begin
      state_nxt = RUN;
    end else begin
      state_nxt = state;
    end
  end

  // Output decode from registered state
  always_comb begin
    tick          = (state != IDLE) && (pre_cnt == pre_max);
    wrap          = tick && (state == RUN) && wrap_hit;
    running       = (state == RUN) || (state == LOAD_WAIT);
    cmd.cmd_ready = (state != LOAD_WAIT);
  end

  // Datapath next values; a command on a tick edge replaces that edge's step
  always_comb begin
    count_nxt = count;
    pre_nxt   = pre_cnt;
    max_nxt   = pre_max;
    pend_nxt  = pend;
    if (accept) begin
      case (cmd.cmd_op)
        OP_START: begin
          max_nxt = prescale;
          pre_nxt = PRE_ZERO;
        end
        OP_STOP: begin
          pre_nxt = PRE_ZERO;
        end
        OP_LOAD: begin
          if (state == IDLE) begin
            count_nxt = cmd.cmd_data;
          end else begin
            // Deferred load keeps the prescaler phase running
            pend_nxt = cmd.cmd_data;
            pre_nxt  = tick ? PRE_ZERO : (pre_cnt + PRE_ONE);
          end
        end
        OP_CLEAR: begin
          count_nxt = 16'h0000;
          pre_nxt   = PRE_ZERO;
        end
        default: begin
          count_nxt = count;
        end
      endcase
    end else if (state != IDLE) begin
      if (tick) begin
        pre_nxt   = PRE_ZERO;
        count_nxt = (state == LOAD_WAIT) ? pend : step_val;
      end else begin
        pre_nxt = pre_cnt + PRE_ONE;
      end
    end else begin
      pre_nxt = PRE_ZERO;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 16'h0000;
      pre_cnt <= PRE_ZERO;
      pre_max <= PRE_ZERO;
      pend    <= 16'h0000;
    end else begin
      count   <= count_nxt;
      pre_cnt <= pre_nxt;
      pre_max <= max_nxt;
      pend    <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_blink_counter.sv
// Self-checking bench for blink_counter: a cycle model feeds a scoreboard queue, plus directed checks.
module tb_blink_counter;

  localparam logic [1:0] START = 2'b00;
  localparam logic [1:0] STOP  = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  typedef struct packed {
    logic [15:0] count;
    logic        tick;
    logic        wrap;
    logic        ready;
    logic        running;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic        dir = 1'b0;
  logic [15:0] current_count;
  logic        tick;
  logic        wrap;
  logic        running;

  blink_counter_if bus ();

  blink_counter #(.PRESCALE_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (bus),
    .prescale      (prescale),
`ifdef BLINK_COUNTER_DIR_EN
    .dir_down      (dir),
`endif
    .current_count (current_count),
    .tick          (tick),
    .wrap          (wrap),
    .running       (running)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_pass  = 0;
  snap_t sb[$];

  // model: 0 idle, 1 run, 2 load-wait
  int          m_state;
  logic [15:0] m_count;
  logic [7:0]  m_pre;
  logic [7:0]  m_max;
  logic [15:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 16'h0000; m_pre = 8'd0; m_max = 8'd0; m_pend = 16'h0000;
    sb.delete();
  endtask

  task automatic model_next(input logic v, input logic [1:0] op, input logic [15:0] d,
                            input logic [7:0] p, output snap_t e);
    logic        t;
    logic        acc;
    int          ns;
    logic [15:0] nc;
    logic [7:0]  npre;
    logic [7:0]  nmax;
    logic [15:0] npend;
    t = (m_state != 0) && (m_pre == m_max);
    acc = v && (m_state != 2);
    ns = m_state; nc = m_count; npre = m_pre; nmax = m_max; npend = m_pend;
    if (m_state != 0) npre = t ? 8'd0 : m_pre + 8'd1;
    if (t) begin
      if (m_state == 2) begin
        nc = m_pend; ns = 1;
      end else begin
        nc = dir ? m_count - 16'd1 : m_count + 16'd1;
      end
    end
    if (acc) begin
      case (op)
        START: begin nmax = p; npre = 8'd0; ns = 1; nc = m_count; end
        STOP:  begin ns = 0; npre = 8'd0; nc = m_count; end
        LOAD:  begin
          if (m_state == 0) nc = d;
          else begin npend = d; ns = 2; nc = m_count; end
        end
        default: begin nc = 16'h0000; npre = 8'd0; end
      endcase
    end
    m_state = ns; m_count = nc; m_pre = npre; m_max = nmax; m_pend = npend;
    e.count   = m_count;
    e.tick    = (m_state != 0) && (m_pre == m_max);
    e.running = (m_state != 0);
    e.ready   = (m_state != 2);
    e.wrap    = e.tick && (m_state == 1) && (dir ? (m_count == 16'h0000) : (m_count == 16'hFFFF));
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d, input logic [7:0] p);
    snap_t e;
    snap_t g;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    prescale      = p;
    model_next(v, op, d, p, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("sb_count", {16'h0, current_count}, {16'h0, g.count});
    chk("sb_tick", {31'h0, tick}, {31'h0, g.tick});
    chk("sb_wrap", {31'h0, wrap}, {31'h0, g.wrap});
    chk("sb_ready", {31'h0, bus.cmd_ready}, {31'h0, g.ready});
    chk("sb_running", {31'h0, running}, {31'h0, g.running});
    bus.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, START, 16'h0000, 8'd0);
  endtask

  int n_ticks;
  int n_wraps;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 16'h0000;
    model_reset();
    #23;
    chk("rst_count", {16'h0, current_count}, 32'h0);
    chk("rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("rst_tick", {31'h0, tick}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    rst_n = 1'b1;

    // Counting at P = 3
    drive(1'b1, START, 16'h0000, 8'd3);
    n_ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (tick) n_ticks++;
    end
    chk("p3_count", {16'h0, current_count}, 32'd5);
    chk("p3_ticks", n_ticks, 32'd5);

    // STOP and resume with P = 1
    drive(1'b1, STOP, 16'h0000, 8'd0);
    idle(50);
    chk("stop_hold", {16'h0, current_count}, 32'd5);
    drive(1'b1, START, 16'h0000, 8'd1);
    chk("resume_tick0", {31'h0, tick}, 32'h0);
    idle(1);
    chk("resume_tick1", {31'h0, tick}, 32'h1);
    idle(1);
    chk("resume_count", {16'h0, current_count}, 32'd6);

    // Deferred load at P = 7
    drive(1'b1, STOP, 16'h0000, 8'd0);
    drive(1'b1, CLEAR, 16'h0000, 8'd0);
    drive(1'b1, START, 16'h0000, 8'd7);
    idle(2);
    drive(1'b1, LOAD, 16'h0100, 8'd0);
    chk("dload_ready_lo", {31'h0, bus.cmd_ready}, 32'h0);
    idle(4);
    chk("dload_ready_hold", {31'h0, bus.cmd_ready}, 32'h0);
    chk("dload_old", {16'h0, current_count}, 32'h0);
    idle(1);
    chk("dload_value", {16'h0, current_count}, 32'h0100);
    chk("dload_ready_hi", {31'h0, bus.cmd_ready}, 32'h1);

    // Wrap at P = 0
    drive(1'b1, STOP, 16'h0000, 8'd0);
    drive(1'b1, LOAD, 16'hFFFE, 8'd0);
    drive(1'b1, START, 16'h0000, 8'd0);
    n_wraps = wrap ? 1 : 0;
    idle(1);
    chk("wrap_ffff", {16'h0, current_count}, 32'hFFFF);
    chk("wrap_hi", {31'h0, wrap}, 32'h1);
    n_wraps += wrap ? 1 : 0;
    idle(1);
    chk("wrap_zero", {16'h0, current_count}, 32'h0);
    n_wraps += wrap ? 1 : 0;
    chk("wrap_once", n_wraps, 32'd1);

    // Commands on tick edges at P = 0: step lost, CLEAR gives zero
    idle(2);
    drive(1'b1, START, 16'h0000, 8'd0);
    chk("tick_start_lost", {16'h0, current_count}, 32'd2);
    drive(1'b1, CLEAR, 16'h0000, 8'd0);
    chk("tick_clear", {16'h0, current_count}, 32'd0);
    drive(1'b1, LOAD, 16'h00AA, 8'd0);
    chk("tick_load_defer", {16'h0, current_count}, 32'd0);
    idle(1);
    chk("tick_load_land", {16'h0, current_count}, 32'h00AA);

`ifdef BLINK_COUNTER_DIR_EN
    // Down counting from 1
    drive(1'b1, STOP, 16'h0000, 8'd0);
    drive(1'b1, LOAD, 16'h0001, 8'd0);
    dir = 1'b1;
    drive(1'b1, START, 16'h0000, 8'd0);
    idle(1);
    chk("down_zero", {16'h0, current_count}, 32'h0);
    chk("down_wrap", {31'h0, wrap}, 32'h1);
    idle(1);
    chk("down_ffff", {16'h0, current_count}, 32'hFFFF);
    dir = 1'b0;
`endif

    // Random command traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
`ifdef BLINK_COUNTER_DIR_EN
      dir = ($urandom_range(0, 3) == 0);
`endif
      drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            16'($urandom), 8'($urandom_range(0, 3)));
    end
    dir = 1'b0;

    // Asynchronous reset mid-run at 0x1234
    drive(1'b1, STOP, 16'h0000, 8'd0);
    drive(1'b1, LOAD, 16'h1234, 8'd0);
    drive(1'b1, START, 16'h0000, 8'd5);
    idle(2);
    chk("pre_rst_count", {16'h0, current_count}, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", {16'h0, current_count}, 32'h0);
    chk("arst_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("arst_running", {31'h0, running}, 32'h0);
    model_reset();
    #2 rst_n = 1'b1;

    // Reset while a load is pending discards it
    drive(1'b1, START, 16'h0000, 8'd5);
    drive(1'b1, LOAD, 16'h4444, 8'd0);
    chk("lw_ready", {31'h0, bus.cmd_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("lw_rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
    model_reset();
    #2 rst_n = 1'b1;
    drive(1'b1, START, 16'h0000, 8'd0);
    idle(3);
    chk("lw_discard", {16'h0, current_count}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blink_counter.md
# blink_counter

Upstream timebase for the blinker stage. Produces the free-running 16-bit `current_count` that the blinker adds its offset to, and advances it at a programmable prescaled rate. Software or the top-level controller drives it through a valid/ready command port (start, stop, load, clear). It also emits per-step `tick` and `wrap` pulses for other consumers.

## Interface
- `PRESCALE_W`, default 8: width of the prescale divisor; the step period is `prescale + 1` clocks.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command; a transfer happens on an edge where valid and ready are both 1.
- `cmd_op`  in  2: command opcode; 00 START, 01 STOP, 10 LOAD, 11 CLEAR.
- `cmd_data`  in  16: LOAD value; ignored for other ops.
- `prescale`  in  PRESCALE_W: divisor minus one; sampled only on an accepted START.
- `dir_down`  in  1: count direction; present only with `BLINK_COUNTER_DIR_EN`.
- `current_count`  out  16: counter value; feeds the blinker's count input.
- `tick`  out  1: high in cycles where the count steps at the next edge.
- `wrap`  out  1: high in cycles where the step also wraps the count.
- `running`  out  1: high in RUN and LOAD_WAIT.

## Operation
- Registers: `state`, `count[15:0]`, `pre_cnt[PRESCALE_W-1:0]`, `pre_max[PRESCALE_W-1:0]`, `pend[15:0]`.
- States:
  - IDLE: count held, pre_cnt = 0, tick = 0.
  - RUN: prescaler active.
  - LOAD_WAIT: RUN with a deferred load pending.
- `tick` = (state != IDLE) && (pre_cnt == pre_max). It is combinational from registers.
- In RUN and LOAD_WAIT, each edge does one of two things:
  - If tick = 1: pre_cnt goes to 0, and count steps.
  - Otherwise: pre_cnt increments.
- Count step:
  - RUN: count + 1, modulo 2^16.
  - LOAD_WAIT: count takes `pend`, then state goes to RUN. No increment happens on that step.
- `wrap` = tick && state == RUN && count == 0xFFFF (up direction). `wrap` never asserts on a load step.
- `cmd_ready` = (state != LOAD_WAIT).
- Accepted commands:
  - START: pre_max takes `prescale`; pre_cnt goes to 0; state goes to RUN; count is unchanged. START while in RUN restarts the prescaler phase.
  - STOP: state goes to IDLE; pre_cnt goes to 0; count is held.
  - LOAD in IDLE: count takes cmd_data at the accept edge.
  - LOAD in RUN: pend takes cmd_data; state goes to LOAD_WAIT. The count keeps its phase, and the load lands on the next tick.
  - CLEAR: count goes to 0 and pre_cnt goes to 0; state is unchanged.
- A command accepted on the same edge as a tick takes priority over that edge's step. The step is lost, and the command's effect is applied instead. The exception is CLEAR, whose effect is 0 regardless.
- `current_count` is driven directly from the `count` register.

## Timing
- Reset values: state IDLE, count 0x0000, pre_cnt 0, pre_max 0, pend 0.
- Reset output values: `cmd_ready` 1, `tick` 0, `wrap` 0, `running` 0, `current_count` 0x0000.
- Reset is asynchronous. It asserts at any time, including in LOAD_WAIT, and the pending load is discarded.
- Command latency: the effect is visible in the cycle after the accept edge.
- Step period: with START accepted at edge E and prescale P, the ticks fall in the cycles ending at edges E+P+1, E+2(P+1), and so on. The count changes at those edges.
- With P = 0, tick is high in every cycle while running.
- Deferred load: the new value appears at the first tick edge after the accept. `cmd_ready` is low from the accept edge until that tick edge.

## Configuration
- Macro: `BLINK_COUNTER_DIR_EN`.
- Defined:
  - The `dir_down` port exists, and it is sampled on each step.
  - When `dir_down` = 1, the step is count − 1, modulo 2^16.
  - `wrap` asserts on a down step from 0x0000, which goes to 0xFFFF.
  - Loads and CLEAR are unaffected by direction.
- Undefined: the port is absent, and the block counts up only.

## Test plan
- Reset check: assert reset mid-run with the count at 0x1234 → the count reads 0x0000 immediately (before any clock), `cmd_ready` = 1, and `running` = 0.
- Counting at P = 3: START with prescale = 3 from count 0 → `tick` pulses every 4th cycle, and the count reads 5 after 20 cycles.
- Wrap: LOAD 0xFFFE in IDLE, then START with P = 0 → the count goes 0xFFFF, then 0x0000, with `wrap` high for exactly the one cycle before the 0x0000 edge.
- Deferred load: in RUN with P = 7, LOAD 0x0100 → `cmd_ready` stays low until the next tick edge, and the count becomes 0x0100 (not old+1) at that edge.
- STOP and resume: STOP mid-period → the count holds for 50 cycles. A following START with P = 1 → the first tick occurs 2 cycles after the accept.
- Down counting (with `BLINK_COUNTER_DIR_EN`): `dir_down` = 1 from count 1 with P = 0 → the count goes 0, then 0xFFFF, with `wrap` high in the 0 → 0xFFFF step cycle.
